// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the wait-state data memory.
// funct3 codes, controller states and a legality helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Unsigned variants only exist for loads.
    function automatic logic f3_legal(
        input logic       we,
        input logic [2:0] f3
    );
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: byte-lane steering for one data-memory word.
// Builds store byte enables/merge and extends load data.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   oword,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rword,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wword,
    output logic [XLEN-1:0]   rdata
);

    localparam int NB = XLEN / 8;

    logic            isb;
    logic            ish;
    logic            sx;
    logic [1:0]      aoff;
    logic [XLEN-1:0] sdata;
    logic [XLEN-1:0] shr;

    // Size decode; the offset is aligned down to the access size.
    always_comb begin
        isb   = (funct3[1:0] == F3_B[1:0]);
        ish   = (funct3[1:0] == F3_H[1:0]);
        sx    = ~funct3[2];
        aoff  = 2'b00;
        be    = '1;
        sdata = wdata;
        unique case (1'b1)
            isb: begin
                aoff  = off;
                be    = NB'(1) << aoff;
                sdata = {NB{wdata[7:0]}};
            end
            ish: begin
                aoff  = {off[1], 1'b0};
                be    = NB'(3) << aoff;
                sdata = {(NB/2){wdata[15:0]}};
            end
            default: begin
                aoff  = 2'b00;
                be    = '1;
                sdata = wdata;
            end
        endcase
    end

    // Merge enabled store lanes over the old word.
    always_comb begin
        wword = oword;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                wword[8*i +: 8] = sdata[8*i +: 8];
            end
        end
    end

    // Right-align the addressed lane and extend it.
    always_comb begin
        shr   = rword >> {aoff, 3'b000};
        rdata = shr;
        unique case (1'b1)
            isb:     rdata = {{(XLEN-8){sx & shr[7]}},
                              shr[7:0]};
            ish:     rdata = {{(XLEN-16){sx & shr[15]}},
                              shr[15:0]};
            default: rdata = shr;
        endcase
    end

endmodule

// File: rtl/dmem_wait.sv
// dmem_wait: data memory with valid/ready channels and wait states.
// Build option: DMEM_MISALIGN_TRAP_EN makes misaligned accesses fault.
module dmem_wait #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int WAIT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    import dmem_pkg::*;

    localparam int          NB     = XLEN / 8;
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [3:0]  WCNT   = 4'(WAIT);
    localparam bit          NOWAIT = (WAIT == 0);
    localparam logic [32:0] LIMIT  = 33'(DEPTH) << 2;

    state_t            state;
    state_t            nstate;
    logic [3:0]        cnt;

    logic              l_we;
    logic [31:0]       l_addr;
    logic [XLEN-1:0]   l_wdata;
    logic [2:0]        l_f3;

    logic              a_we;
    logic [31:0]       a_addr;
    logic [XLEN-1:0]   a_wdata;
    logic [2:0]        a_f3;

    logic              accept;
    logic              exec;
    logic              illegal;
    logic              oor;
    logic              mis;
    logic              err;
    logic              wr;

    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   word;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   st_word;
    logic [XLEN-1:0]   ld_data;

    logic [XLEN-1:0]   mem [DEPTH];

    // With no wait states the access runs on the
    // accepting edge, so it must see live inputs.
    assign a_we    = (state == IDLE) ? req_we     : l_we;
    assign a_addr  = (state == IDLE) ? req_addr   : l_addr;
    assign a_wdata = (state == IDLE) ? req_wdata  : l_wdata;
    assign a_f3    = (state == IDLE) ? req_funct3 : l_f3;

    assign accept = (state == IDLE) && req_valid;
    assign exec   = (accept && NOWAIT)
                 || (state == dmem_pkg::WAIT
                     && cnt == 4'd1);

    assign illegal = ~f3_legal(a_we, a_f3);
    assign oor     = ({1'b0, a_addr} >= LIMIT);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = ((a_f3[1:0] == F3_H[1:0])
                  && a_addr[0])
              || ((a_f3[1:0] == F3_W[1:0])
                  && (a_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign err = illegal | oor | mis;
    assign wr  = exec & a_we & ~err;

    assign idx  = a_addr[2 +: AW];
    assign word = mem[idx];

    dmem_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .funct3 (a_f3),
        .off    (a_addr[1:0]),
        .oword  (word),
        .wdata  (a_wdata),
        .rword  (word),
        .be     (be),
        .wword  (st_word),
        .rdata  (ld_data)
    );

    // Next-state and handshake outputs.
    always_comb begin
        nstate    = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nstate = NOWAIT ? RESP
                                    : dmem_pkg::WAIT;
                end
            end
            dmem_pkg::WAIT: begin
                if (cnt == 4'd1) begin
                    nstate = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // State register and wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nstate;
            if (accept) begin
                cnt <= WCNT;
            end else if (state == dmem_pkg::WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Capture the request so later req_* changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            l_f3    <= 3'b000;
        end else if (accept) begin
            l_we    <= req_we;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_f3    <= req_funct3;
        end
    end

    // Response registers: loaded on entry to RESP,
    // cleared once the consumer takes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (exec) begin
            rsp_err   <= err;
            rsp_rdata <= (err || a_we) ? '0 : ld_data;
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_wait.sv
// tb_dmem_wait: directed plus random checks of dmem_wait (WAIT=2)
// against a byte-array reference model.
module tb_dmem_wait;

    localparam int WAITV = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] bm [4096];

    always #5 clk = ~clk;

    dmem_wait #(
        .XLEN  (32),
        .DEPTH (1024),
        .WAIT  (WAITV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h",
                   tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, size from funct3,
    // sign extension by arithmetic.
    task automatic model(input bit we, input bit [2:0] f3,
                         input bit [31:0] addr,
                         input bit [31:0] wd,
                         output bit [31:0] erd,
                         output bit eerr);
        int     size;
        bit     legal;
        bit     oor;
        bit     mis;
        int     base;
        longint v;
        legal = we ? (f3 <= 3'd2)
                   : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        oor   = (addr >= 32'h1000);
        mis   = TRAP && ((addr & 32'(size - 1)) != 0);
        eerr  = !legal || oor || mis;
        erd   = 32'h0;
        if (!eerr) begin
            base = int'(addr & ~32'(size - 1));
            if (we) begin
                for (int k = 0; k < size; k++)
                    bm[base + k] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < size; k++)
                    v = v + (longint'(bm[base + k]) << (8 * k));
                if (!f3[2] && size < 4
                    && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                erd = v[31:0];
            end
        end
    endtask

    // One full transaction starting and ending at a negedge.
    task automatic xact(input bit we, input bit [2:0] f3,
                        input bit [31:0] addr,
                        input bit [31:0] wd,
                        input int hold,
                        output logic [31:0] ord,
                        output logic oerr);
        bit [31:0] erd;
        bit        eerr;
        int        lat;
        model(we, f3, addr, wd, erd, eerr);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        rsp_ready  = 1'b0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_we     = ~we;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            chk("req_ready_wait", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(WAITV + 1));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, erd);
            chk("hold_err", 32'(rsp_err), 32'(eerr));
            chk("hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        ord  = rsp_rdata;
        oerr = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", 32'(rsp_valid), 32'd0);
        chk("done_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        bit [2:0]    lf [5];
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2;
        lf[3] = 3'd4; lf[4] = 3'd5;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++)
            xact(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd, er);

        xact(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
        chk("sw10_err", 32'(er), 32'd0);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("lw10", rd, 32'hDEADBEEF);

        xact(1'b1, 3'd0, 32'h13, 32'h80, 0, rd, er);
        xact(1'b0, 3'd0, 32'h13, 32'h0, 0, rd, er);
        chk("lb13", rd, 32'hFFFFFF80);
        xact(1'b0, 3'd4, 32'h13, 32'h0, 1, rd, er);
        chk("lbu13", rd, 32'h00000080);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("lw10_b", rd, 32'h80ADBEEF);

        xact(1'b1, 3'd1, 32'h20, 32'h1234, 5, rd, er);
        chk("sh20_err", 32'(er), 32'd0);

        xact(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'h0);
        xact(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, er);
        chk("f3_011_err", 32'(er), 32'd1);
        xact(1'b1, 3'd2, 32'h1010, 32'hFFFFFFFF, 0, rd, er);
        chk("sw_oor_err", 32'(er), 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
        chk("sw_oor_kept", rd, 32'h80ADBEEF);

        xact(1'b0, 3'd1, 32'h21, 32'h0, 0, rd, er);
        chk("lh21_err", 32'(er), TRAP ? 32'd1 : 32'd0);
        chk("lh21_rdata", rd, TRAP ? 32'h0 : 32'h1234);

        xact(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 0, rd, er);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h30;
        req_wdata  = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rdata", rsp_rdata, 32'h0);
        chk("abort_err", 32'(rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        xact(1'b0, 3'd2, 32'h30, 32'h0, 0, rd, er);
        chk("abort_lw30", rd, 32'hCAFEF00D);

        for (int n = 0; n < 150; n++) begin
            bit        w;
            bit [2:0]  f;
            bit [31:0] a;
            int        sel;
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            f   = (sel == 0) ? 3'($urandom_range(0, 7))
                             : lf[$urandom_range(0, 4)];
            if (sel == 1)
                a = 32'h1000 + 32'($urandom_range(0, 1 << 20));
            else if (sel == 2)
                a = 32'h10000 | $urandom;
            else
                a = 32'($urandom_range(0, 255));
            xact(w, f, a, $urandom, $urandom_range(0, 2), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
